// File: rtl/avalon_st_mul_responder.sv
// Avalon-ST multiply responder.
// Receives a request packet of N = 2*SZ/DSZ beats carrying operands A then B
// (each little-endian). Returns a response packet of N beats carrying the full
// 2*SZ-bit unsigned product A*B, also little-endian.
// Malformed requests are dropped, and each one raises a one-cycle err pulse.
module avalon_st_mul_responder #(
    parameter int SZ  = 32,
    parameter int DSZ = 8
) (
    input  logic           clk,
    input  logic           _rst,

    // Sink (request) side
    input  logic [DSZ-1:0] data_in,
    input  logic           valid_in,
    input  logic           startofpacket_in,
    input  logic           endofpacket_in,
    output logic           ready_out,

    // Source (response) side
    output logic [DSZ-1:0] data_out,
    output logic           valid_out,
    output logic           startofpacket_out,
    output logic           endofpacket_out,
    input  logic           ready_in,

    // Status
    output logic           busy,
    output logic           err
);

    // Beats per packet. Requests and responses are both 2*SZ bits wide.
    localparam int N     = (2 * SZ) / DSZ;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        CALC,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;    // beat index within the current packet
    logic [2*SZ-1:0]   opnd_q,  opnd_d;   // {B, A} as it is assembled from beats
    logic [2*SZ-1:0]   prod_q,  prod_d;   // registered product that is streamed out
    logic              err_q,   err_d;    // registered violation pulse
    logic              live_q,  live_d;   // low in reset, high from the first edge after release

    logic              sink_fire;
    logic              src_fire;
    logic              sink_open;
    logic [SZ-1:0]     opnd_a;
    logic [SZ-1:0]     opnd_b;
    logic [DSZ-1:0]    send_beat;

    // The sink is open while a request can be accepted, and never before the
    // first clock edge after reset is released.
    assign sink_open = (state_q == IDLE) || (state_q == RECV) || (state_q == DRAIN);
    assign ready_out = live_q && sink_open;

    assign sink_fire = valid_in && ready_out;
    assign src_fire  = valid_out && ready_in;

    // A occupies the first SZ/DSZ beats, so it sits in the low half.
    assign opnd_a = opnd_q[SZ-1:0];
    assign opnd_b = opnd_q[2*SZ-1:SZ];

    // The beat counter advances only on a source transfer, so this slice stays
    // stable while the downstream stalls.
    assign send_beat = prod_q[int'(cnt_q) * DSZ +: DSZ];

    // Source outputs are decoded from state, so they are zero outside SEND and in reset.
    assign valid_out         = (state_q == SEND);
    assign data_out          = valid_out ? send_beat : '0;
    assign startofpacket_out = valid_out && (cnt_q == '0);
    assign endofpacket_out   = valid_out && (cnt_q == LAST);

    assign busy = (state_q != IDLE);
    assign err  = err_q;

    // Next-state logic: request parsing, product capture and response sequencing.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        err_d   = 1'b0;
        live_d  = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sink_fire) begin
                    if (startofpacket_in && !endofpacket_in) begin
                        opnd_d[DSZ-1:0] = data_in;
                        cnt_d           = CNT_W'(1);
                        state_d         = RECV;
                    end else begin
                        // Stray beat, or a packet that is one beat long: drop it.
                        err_d = 1'b1;
                    end
                end
            end

            RECV: begin
                if (sink_fire) begin
                    if (startofpacket_in && endofpacket_in) begin
                        // A new single-beat packet: the partial packet and this beat are both dropped.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (startofpacket_in) begin
                        // A new packet starts: this beat becomes its first beat.
                        opnd_d[DSZ-1:0] = data_in;
                        cnt_d           = CNT_W'(1);
                        err_d           = 1'b1;
                    end else if (cnt_q != LAST) begin
                        if (endofpacket_in) begin
                            // Packet too short.
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            opnd_d[int'(cnt_q) * DSZ +: DSZ] = data_in;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        opnd_d[int'(cnt_q) * DSZ +: DSZ] = data_in;
                        cnt_d = '0;
                        if (endofpacket_in) begin
                            state_d = CALC;
                        end else begin
                            // Packet too long: swallow the rest of it quietly.
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                cnt_d = '0;
                if (sink_fire && endofpacket_in) begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                // Zero-extend both operands so the product keeps all 2*SZ bits.
                prod_d  = {{SZ{1'b0}}, opnd_a} * {{SZ{1'b0}}, opnd_b};
                cnt_d   = '0;
                state_d = SEND;
            end

            SEND: begin
                if (src_fire) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset clears control, operands and the product.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            // NOTE: the operand and product registers are cleared as well as the
            // control state, so no data from an aborted transaction survives a reset.
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its _d value
            // from before the edge, whatever order these lines are in.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_avalon_st_mul_responder.sv
// Self-checking bench for avalon_st_mul_responder (SZ=32, DSZ=8, N=8).
// The reference is a queue of expected response bytes built from A*B. A
// monitor compares every source transfer against that queue and checks that
// the outputs hold stable while the sink is stalled. Directed tests then check
// the captured beats against literal byte listings.
module tb_avalon_st_mul_responder;

    localparam int SZ  = 32;
    localparam int DSZ = 8;
    localparam int N   = 2 * SZ / DSZ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       startofpacket_in;
    logic       endofpacket_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       startofpacket_out;
    logic       endofpacket_out;
    logic       ready_in;
    logic       busy;
    logic       err;

    int errors   = 0;
    int checks   = 0;
    int err_seen = 0;
    int tx_total = 0;
    int tx_idx   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    bit   prev_valid;
    bit   prev_ready;
    logic [7:0] prev_data;
    logic prev_sop;
    logic prev_eop;

    bit pat [3] = '{1'b1, 1'b0, 1'b0};

    avalon_st_mul_responder #(.SZ(SZ), .DSZ(DSZ)) dut (
        .clk               (clk),
        ._rst              (rst_n),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .startofpacket_in  (startofpacket_in),
        .endofpacket_in    (endofpacket_in),
        .ready_out         (ready_out),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .ready_in          (ready_in),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: the outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            tx_idx     = 0;
        end else begin
            if (err) err_seen++;
            if (!valid_out) begin
                check("idle_sop_eop", {startofpacket_out, endofpacket_out}, 2'b00);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", valid_out, 1'b1);
                check("stall_data", data_out, prev_data);
                check("stall_flags", {startofpacket_out, endofpacket_out}, {prev_sop, prev_eop});
            end
            if (valid_out && ready_in) begin
                check("resp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("resp_data", data_out, exp_q.pop_front());
                    check("resp_sop", startofpacket_out, tx_idx == 0);
                    check("resp_eop", endofpacket_out, tx_idx == N - 1);
                end
                got_q.push_back(data_out);
                tx_total++;
                tx_idx = (tx_idx == N - 1) ? 0 : tx_idx + 1;
            end
            prev_valid = valid_out;
            prev_ready = ready_in;
            prev_data  = data_out;
            prev_sop   = startofpacket_out;
            prev_eop   = endofpacket_out;
        end
    end

    // Drives one sink beat and returns just after the edge that accepts it.
    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        int n;
        data_in          = d;
        startofpacket_in = s;
        endofpacket_in   = e;
        valid_in         = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            n++;
            if (n > 200) begin
                check("sink_ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
    endtask

    // Sends a well-formed request and adds the bytes of A*B to the expected queue.
    task automatic send_req(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] req;
        logic [63:0] p;
        req = {b, a};
        p   = 64'(a) * 64'(b);
        for (int i = 0; i < N; i++) exp_q.push_back(p[8*i +: 8]);
        for (int i = 0; i < N; i++) send_beat(req[8*i +: 8], i == 0, i == N - 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    // The literal lists beat 0 first, in the leftmost byte.
    task automatic check_beats(input string name, input logic [63:0] lit);
        check({name, "_count"}, got_q.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got_q.size()) check(name, got_q[i], lit[63 - 8*i -: 8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int t0;
        int n;
        int ph;

        rst_n            = 1'b0;
        data_in          = '0;
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
        ready_in         = 1'b1;

        // Reset state.
        #1;
        check("rst_outputs", {ready_out, valid_out, busy, err, startofpacket_out, endofpacket_out}, 6'b0);
        check("rst_data", data_out, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", ready_out, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after_edge", ready_out, 1'b1);

        // A=1, B=2: check latency, then the beats.
        got_q.delete();
        e0 = err_seen;
        send_req(32'd1, 32'd2);
        @(negedge clk);
        check("calc_valid", valid_out, 1'b0);
        check("calc_busy", busy, 1'b1);
        @(negedge clk);
        check("first_valid", valid_out, 1'b1);
        check("first_sop", startofpacket_out, 1'b1);
        check("first_data", data_out, 8'h02);
        wait_idle("t1");
        check_beats("t1_beats", 64'h02_00_00_00_00_00_00_00);
        check("t1_err", err_seen - e0, 0);

        // A=B=0xFFFFFFFF: the full product, with no truncation.
        got_q.delete();
        e0 = err_seen;
        send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("t2");
        check_beats("t2_beats", 64'h01_00_00_00_FE_FF_FF_FF);
        check("t2_err", err_seen - e0, 0);

        // A=0x12345678, B=0x10, with ready_in toggling 1,0,0,...
        got_q.delete();
        t0 = tx_total;
        send_req(32'h1234_5678, 32'h10);
        ph = 0;
        n  = 0;
        while (tx_total - t0 < N && n < 300) begin
            ready_in = pat[ph % 3];
            ph++;
            @(posedge clk);
            #1;
            n++;
        end
        ready_in = 1'b1;
        wait_idle("t3");
        check_beats("t3_beats", 64'h80_67_45_23_01_00_00_00);
        check("t3_transfers", tx_total - t0, N);

        // A 5-beat request that ends early, then 1*2.
        got_q.delete();
        e0 = err_seen;
        t0 = tx_total;
        for (int i = 0; i < 5; i++) send_beat(8'hA0 + 8'(i), i == 0, i == 4);
        repeat (4) @(posedge clk);
        #1;
        check("t4_err", err_seen - e0, 1);
        check("t4_no_resp", tx_total - t0, 0);
        check("t4_idle", busy, 1'b0);
        send_req(32'd1, 32'd2);
        wait_idle("t4b");
        check_beats("t4_beats", 64'h02_00_00_00_00_00_00_00);

        // SOP again at beat 3, then a full valid 3*3 packet.
        got_q.delete();
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send_beat(8'h55, i == 0, 1'b0);
        send_req(32'd3, 32'd3);
        wait_idle("t5");
        check_beats("t5_beats", 64'h09_00_00_00_00_00_00_00);
        check("t5_err", err_seen - e0, 1);

        // Stray beat in IDLE, a beat with SOP and EOP together, and an over-long packet.
        e0 = err_seen;
        t0 = tx_total;
        send_beat(8'h11, 1'b0, 1'b0);
        send_beat(8'h22, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) send_beat(8'h33, i == 0, 1'b0);
        send_beat(8'h44, 1'b1, 1'b0);
        send_beat(8'h45, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("t6_err", err_seen - e0, 3);
        check("t6_no_resp", tx_total - t0, 0);
        check("t6_idle", busy, 1'b0);

        // Reset while beat 4 of a response is on the outputs.
        got_q.delete();
        t0 = tx_total;
        send_req(32'h1122_3344, 32'h5566_7788);
        n = 0;
        while (tx_total - t0 < 4 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t7_mid_send", valid_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_outputs", {ready_out, valid_out, busy, err, startofpacket_out, endofpacket_out}, 6'b0);
        check("t7_rst_data", data_out, 8'h00);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t7_ready_low", ready_out, 1'b0);
        @(posedge clk);
        #1;
        check("t7_ready_high", ready_out, 1'b1);
        check("t7_partial", tx_total - t0, 4);
        got_q.delete();
        send_req(32'd1, 32'd2);
        wait_idle("t7b");
        check_beats("t7_beats", 64'h02_00_00_00_00_00_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
